// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller.
//   - SDRAM command encodings {cs_n, ras_n, cas_n, we_n}
//   - one-hot state constants for the command-bus arbiter
package sdram_pkg;

    localparam logic [3:0] CMD_NOP          = 4'b1000;
    localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
    localparam logic [3:0] CMD_READ         = 4'b0101;
    localparam logic [3:0] CMD_WRITE        = 4'b0100;
    localparam logic [3:0] CMD_BURST_TERM   = 4'b0110;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;

    // Bank address used when no engine cares about the bank.
    localparam logic [1:0] BA_ALL = 2'b11;

    typedef enum logic [4:0] {
        ARB_INIT  = 5'b00001,
        ARB_ARBIT = 5'b00010,
        ARB_AREF  = 5'b00100,
        ARB_WRITE = 5'b01000,
        ARB_READ  = 5'b10000
    } arbit_state_t;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter and sequencer.
// Holds the bus for the init engine until init_end, then grants the
// refresh, write and read engines one at a time (refresh > write > read),
// drives each engine's enable and muxes the granted engine's outputs onto
// the SDRAM pins.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   init_*                     init engine handshake / command / address
//   aref_*, wr_*, rd_*         engine request, end pulse, command, address
//   wr_sdram_en/wr_sdram_data  write engine data drive
//   aref_en, wr_en, rd_en      registered grants to the engines
//   sdram_*                    SDRAM pins (cke tied high, dq bidirectional)
//   rd_sdram_data              sdram_dq as seen by the read engine
//
// state | meaning
// INIT  | init engine owns the bus until init_end
// ARBIT | bus idle (NOP), pick next engine by priority
// AREF  | refresh engine owns the bus until aref_end
// WRITE | write engine owns the bus until wr_end
// READ  | read engine owns the bus until rd_end
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [1:0]        init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [1:0]        wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DATA_W-1:0] wr_sdram_data,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [1:0]        rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [1:0]        sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    inout  wire  [DATA_W-1:0] sdram_dq,
    output logic [DATA_W-1:0] rd_sdram_data
);

    arbit_state_t state;
    arbit_state_t state_next;
    logic [3:0]   cmd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_INIT;
        end else begin
            state <= state_next;
        end
    end

    // The return to ARBIT on an *_end edge makes no grant decision, so the
    // engine sees its enable low in its IDLE cycle and does not restart.
    always_comb begin
        state_next = state;
        unique case (state)
            ARB_INIT:  if (init_end) state_next = ARB_ARBIT;
            ARB_ARBIT: begin
                if (aref_req)      state_next = ARB_AREF;
                else if (wr_req)   state_next = ARB_WRITE;
                else if (rd_req)   state_next = ARB_READ;
            end
            ARB_AREF:  if (aref_end) state_next = ARB_ARBIT;
            ARB_WRITE: if (wr_end)   state_next = ARB_ARBIT;
            ARB_READ:  if (rd_end)   state_next = ARB_ARBIT;
            default:   state_next = ARB_INIT;
        endcase
    end

    // Enables are registered from the next state so they change on the same
    // edge as the state itself; only one can ever be high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aref_en <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
        end else begin
            aref_en <= (state_next == ARB_AREF);
            wr_en   <= (state_next == ARB_WRITE);
            rd_en   <= (state_next == ARB_READ);
        end
    end

    always_comb begin
        cmd        = CMD_NOP;
        sdram_ba   = BA_ALL;
        sdram_addr = '1;
        unique case (state)
            ARB_INIT: begin
                cmd        = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            ARB_AREF: begin
                cmd        = aref_cmd;
                sdram_addr = aref_addr;
            end
            ARB_WRITE: begin
                cmd        = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            ARB_READ: begin
                cmd        = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: begin
                cmd        = CMD_NOP;
                sdram_ba   = BA_ALL;
                sdram_addr = '1;
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    assign sdram_cke     = 1'b1;
    assign sdram_dq      = (state == ARB_WRITE && wr_sdram_en) ? wr_sdram_data : {DATA_W{1'bz}};
    assign rd_sdram_data = sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit: a priority table, hand-written
// multi-cycle sequences, then randomized traffic against a bus-ownership model.
module tb_sdram_arbit;

    logic        clk;
    logic        rst_n;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [12:0] init_addr;
    logic        aref_req, aref_end;
    logic [3:0]  aref_cmd;
    logic [12:0] aref_addr;
    logic        wr_req, wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [12:0] wr_addr;
    logic        wr_sdram_en;
    logic [15:0] wr_sdram_data;
    logic        rd_req, rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ba;
    logic [12:0] rd_addr;
    logic        aref_en, wr_en, rd_en;
    logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    wire  [15:0] sdram_dq;
    logic [15:0] rd_sdram_data;

    // Bench-side driver on the data bus, used to show the DUT is not driving.
    logic        tb_oe;
    logic [15:0] tb_dq;
    assign sdram_dq = tb_oe ? tb_dq : 16'hzzzz;

    int checks   = 0;
    int failures = 0;

    sdram_arbit #(.DATA_W(16), .ADDR_W(13)) dut (
        .clk(clk), .rst_n(rst_n),
        .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_dq(sdram_dq), .rd_sdram_data(rd_sdram_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_en(input string name, input logic [2:0] exp);
        chk(name, {29'd0, aref_en, wr_en, rd_en}, {29'd0, exp});
    endtask

    task automatic chk_pins(input string name, input logic [3:0] c, input logic [1:0] b,
                            input logic [12:0] a);
        chk(name, {13'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr},
                  {13'd0, c, b, a});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Bus-ownership model: who holds the bus, and whether init is done.
    // owner: 0 = nobody (idle bus), 1 = refresh, 2 = write, 3 = read
    bit m_init_done;
    int m_owner;

    task automatic model_step();
        if (!m_init_done) begin
            if (init_end) m_init_done = 1;
        end else if (m_owner == 0) begin
            if (aref_req)    m_owner = 1;
            else if (wr_req) m_owner = 2;
            else if (rd_req) m_owner = 3;
        end else if ((m_owner == 1 && aref_end) || (m_owner == 2 && wr_end) ||
                     (m_owner == 3 && rd_end)) begin
            m_owner = 0;
        end
    endtask

    function automatic bit m_drives();
        return m_init_done && m_owner == 2 && wr_sdram_en;
    endfunction

    task automatic model_check(input int cyc);
        logic [3:0]  ec;
        logic [1:0]  eb;
        logic [12:0] ea;
        logic [2:0]  een;
        een = {m_init_done && m_owner == 1, m_init_done && m_owner == 2, m_init_done && m_owner == 3};
        if (!m_init_done)      begin ec = init_cmd; eb = init_ba; ea = init_addr; end
        else if (m_owner == 1) begin ec = aref_cmd; eb = 2'b11;   ea = aref_addr; end
        else if (m_owner == 2) begin ec = wr_cmd;   eb = wr_ba;   ea = wr_addr;   end
        else if (m_owner == 3) begin ec = rd_cmd;   eb = rd_ba;   ea = rd_addr;   end
        else                   begin ec = 4'b1000;  eb = 2'b11;   ea = 13'h1FFF;  end
        chk($sformatf("rand_en[%0d]", cyc), {29'd0, aref_en, wr_en, rd_en}, {29'd0, een});
        chk_pins($sformatf("rand_pins[%0d]", cyc), ec, eb, ea);
        if (m_drives()) chk($sformatf("rand_dq_wr[%0d]", cyc), {16'd0, sdram_dq}, {16'd0, wr_sdram_data});
        else            chk($sformatf("rand_dq_hiz[%0d]", cyc), {16'd0, rd_sdram_data}, {16'd0, tb_dq});
    endtask

    typedef struct {
        logic       a, w, r;
        logic [2:0] exp_en;
    } vec_t;
    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 3'b000};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 3'b001};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 3'b010};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 3'b010};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 3'b100};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 3'b100};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 3'b100};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 3'b100};

        rst_n = 0; init_end = 0;
        init_cmd = 4'b0010; init_ba = 2'b01; init_addr = 13'h0ABC;
        aref_req = 0; aref_end = 0; aref_cmd = 4'b0001; aref_addr = 13'h0400;
        wr_req = 0; wr_end = 0; wr_cmd = 4'b0100; wr_ba = 2'b10; wr_addr = 13'h0123;
        wr_sdram_en = 0; wr_sdram_data = 16'hA5A5;
        rd_req = 0; rd_end = 0; rd_cmd = 4'b0101; rd_ba = 2'b01; rd_addr = 13'h0456;
        tb_oe = 0; tb_dq = 16'h0000;

        // 1. reset and init hold
        #2;
        chk("reset_cke", {31'd0, sdram_cke}, 32'd1);
        chk_en("reset_en", 3'b000);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 20; i++) tick();
        chk_en("init_hold_en", 3'b000);
        chk_pins("init_hold_pins", 4'b0010, 2'b01, 13'h0ABC);
        chk("init_cke", {31'd0, sdram_cke}, 32'd1);
        init_end = 1;
        #1;
        chk_pins("init_end_same_cycle", 4'b0010, 2'b01, 13'h0ABC);
        tick();
        chk_pins("arbit_nop", 4'b1000, 2'b11, 13'h1FFF);

        // priority table
        foreach (vecs[i]) begin
            aref_req = vecs[i].a; wr_req = vecs[i].w; rd_req = vecs[i].r;
            tick();
            chk_en($sformatf("prio_en[%0d]", i), vecs[i].exp_en);
            aref_req = 0; wr_req = 0; rd_req = 0;
            aref_end = 1; wr_end = 1; rd_end = 1;
            tick();
            aref_end = 0; wr_end = 0; rd_end = 0;
            chk_en($sformatf("prio_ret_en[%0d]", i), 3'b000);
            chk_pins($sformatf("prio_ret_pins[%0d]", i), 4'b1000, 2'b11, 13'h1FFF);
        end

        // 2. simultaneous requests served in order with an ARBIT gap
        aref_req = 1; wr_req = 1; rd_req = 1;
        tick();
        chk_en("seq_aref_en", 3'b100);
        chk_pins("seq_aref_pins", 4'b0001, 2'b11, 13'h0400);
        aref_req = 0; aref_end = 1;
        tick();
        aref_end = 0;
        chk_en("seq_gap1_en", 3'b000);
        chk_pins("seq_gap1_pins", 4'b1000, 2'b11, 13'h1FFF);
        tick();
        chk_en("seq_wr_en", 3'b010);
        chk_pins("seq_wr_pins", 4'b0100, 2'b10, 13'h0123);
        wr_req = 0; wr_end = 1;
        tick();
        wr_end = 0;
        chk_en("seq_gap2_en", 3'b000);
        tick();
        chk_en("seq_rd_en", 3'b001);
        chk_pins("seq_rd_pins", 4'b0101, 2'b01, 13'h0456);
        rd_req = 0; rd_end = 1;
        tick();
        rd_end = 0;
        chk_en("seq_gap3_en", 3'b000);

        // 3. write data drive
        wr_req = 1;
        tick();
        wr_req = 0;
        wr_sdram_en = 1;
        #1;
        chk("dq_write_drive", {16'd0, sdram_dq}, 32'h0000A5A5);
        wr_sdram_en = 0; tb_oe = 1; tb_dq = 16'h3C3C;
        #1;
        chk("dq_write_hiz", {16'd0, rd_sdram_data}, 32'h00003C3C);
        tb_oe = 0;

        // 4. refresh request during a 10-cycle burst waits for wr_end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) aref_req = 1;
            tick();
            chk_en($sformatf("burst_en[%0d]", i), 3'b010);
        end
        wr_end = 1;
        tick();
        wr_end = 0;
        chk_en("burst_end_en", 3'b000);
        tick();
        chk_en("burst_aref_en", 3'b100);
        aref_req = 0; aref_end = 1;
        tick();
        aref_end = 0;

        // 6. foreign end pulses ignored in WRITE
        wr_req = 1;
        tick();
        wr_req = 0;
        rd_end = 1; aref_end = 1;
        tick();
        rd_end = 0; aref_end = 0;
        chk_en("foreign_end_en", 3'b010);
        chk_pins("foreign_end_pins", 4'b0100, 2'b10, 13'h0123);
        wr_end = 1;
        tick();
        wr_end = 0;

        // 5. reset during READ
        rd_req = 1;
        tick();
        rd_req = 0;
        chk_en("read_en", 3'b001);
        tb_oe = 1; tb_dq = 16'h1234;
        #1;
        chk("read_data_in", {16'd0, rd_sdram_data}, 32'h00001234);
        wr_sdram_en = 1; tb_dq = 16'h0F0F;
        rst_n = 0;
        #1;
        chk_en("rst_mid_en", 3'b000);
        chk_pins("rst_mid_pins", 4'b0010, 2'b01, 13'h0ABC);
        chk("rst_mid_dq", {16'd0, sdram_dq}, 32'h00000F0F);
        chk("rst_mid_cke", {31'd0, sdram_cke}, 32'd1);
        tb_oe = 0; wr_sdram_en = 0;
        @(negedge clk);
        rst_n = 1;
        tick();
        chk_pins("rst_recover_arbit", 4'b1000, 2'b11, 13'h1FFF);

        // randomized traffic against the ownership model
        rst_n = 0; init_end = 0;
        #1;
        m_init_done = 0; m_owner = 0;
        @(negedge clk);
        rst_n = 1;
        tb_oe = 1; tb_dq = 16'($urandom);
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            model_step();
            tb_oe = !m_drives();
            @(negedge clk);
            model_check(c);
            if (!init_end && $urandom_range(0, 7) == 0) init_end = 1;
            if (!(aref_req && m_owner != 1)) aref_req = ($urandom_range(0, 4) == 0);
            wr_req   = ($urandom_range(0, 2) == 0);
            rd_req   = ($urandom_range(0, 2) == 0);
            aref_end = ($urandom_range(0, 5) == 0);
            wr_end   = ($urandom_range(0, 5) == 0);
            rd_end   = ($urandom_range(0, 5) == 0);
            init_cmd = 4'($urandom); init_ba = 2'($urandom); init_addr = 13'($urandom);
            aref_cmd = 4'($urandom); aref_addr = 13'($urandom);
            wr_cmd = 4'($urandom); wr_ba = 2'($urandom); wr_addr = 13'($urandom);
            rd_cmd = 4'($urandom); rd_ba = 2'($urandom); rd_addr = 13'($urandom);
            wr_sdram_en = 1'($urandom); wr_sdram_data = 16'($urandom);
            tb_dq = 16'($urandom);
            tb_oe = !m_drives();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
